// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
package mem_access_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned MEM_IDX_W  = 6;

  localparam logic [1:0] SZ_WORD  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_BYTE  = 2'b10;
  localparam logic [1:0] SZ_WORD2 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Registered copy of an accepted request
  typedef struct packed {
    logic                  port;
    logic                  we;
    logic [1:0]            flag;
    logic [1:0]            off;
    logic [DEF_DATA_W-1:0] wdata;
  } req_t;

  function automatic logic is_word(input logic [1:0] flag);
    return (flag == SZ_WORD) || (flag == SZ_WORD2);
  endfunction

  function automatic logic misaligned(input logic [1:0] flag, input logic [1:0] off);
    case (flag)
      SZ_HALF: return off[0];
      SZ_BYTE: return 1'b0;
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Requester, response and memory-side signals of the access controller.
interface mem_access_ctrl_if
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned MEM_AW = MEM_IDX_W
);
  logic                  req0_valid, req1_valid;
  logic                  req0_ready, req1_ready;
  logic                  req0_we, req1_we;
  logic [1:0]            req0_flag, req1_flag;
  logic [ADDR_W-1:0]     req0_addr, req1_addr;
  logic [DEF_DATA_W-1:0] req0_wdata, req1_wdata;
  logic                  rsp0_valid, rsp1_valid;
  logic [DEF_DATA_W-1:0] rsp0_rdata, rsp1_rdata;
  logic                  rsp0_err, rsp1_err;
  logic                  mem_en, mem_we;
  logic [MEM_AW-1:0]     mem_addr;
  logic [DEF_DATA_W-1:0] mem_wdata, mem_rdata;
  logic                  busy;

  modport slave (
    input  req0_valid, req0_we, req0_flag, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_flag, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp0_err,
    output rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0_valid, req0_we, req0_flag, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_flag, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp0_err,
    input  rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_access_ctrl_lane_merge.sv
// Little-endian lane extract (loads) and lane insert (stores) on a full word.
module lane_merge
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]            flag,
  input  logic [1:0]            off,
  input  logic [DEF_DATA_W-1:0] old_word,
  input  logic [DEF_DATA_W-1:0] wdata,
  output logic [DEF_DATA_W-1:0] ext_c,
  output logic [DEF_DATA_W-1:0] merged_c
);
  logic [4:0] sh;
  assign sh = {off, 3'b000};

  // Select lane by size and byte offset; word size passes straight through
  always_comb begin
    ext_c    = old_word;
    merged_c = wdata;
    case (flag)
      SZ_HALF: begin
        if (off[1]) begin
          ext_c    = {16'h0000, old_word[31:16]};
          merged_c = {wdata[15:0], old_word[15:0]};
        end else begin
          ext_c    = {16'h0000, old_word[15:0]};
          merged_c = {old_word[31:16], wdata[15:0]};
        end
      end
      SZ_BYTE: begin
        ext_c             = 32'(old_word[sh +: 8]);
        merged_c          = old_word;
        merged_c[sh +: 8] = wdata[7:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// Two-port round-robin arbiter and load/store/RMW sequencer for a word memory.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned MEM_AW = MEM_IDX_W
) (
  input logic clk,
  input logic rst_n,
  mem_access_ctrl_if.slave bus
);
  state_t              state, state_n;
  req_t                r, r_n, sel;
  logic                ptr, ptr_n;
  logic [1:0]          ready_q, ready_n, acc;
  logic [1:0]          rsp_valid_q, rsp_valid_n;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_n;
  logic                rsp_err_q, rsp_err_n;
  logic                mem_en_q, mem_en_n, mem_we_q, mem_we_n;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_n, sel_idx;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_n;
  logic                busy_q, busy_n;
  logic                sel_err, port_n;
  logic [DATA_W-1:0]   ext_c, merged_c;
  logic                unused_addr;

  assign unused_addr = ^{bus.req0_addr[ADDR_W-1:MEM_AW+2], bus.req1_addr[ADDR_W-1:MEM_AW+2]};

  assign acc = (state == ST_IDLE) ? (ready_q & {bus.req1_valid, bus.req0_valid}) : 2'b00;

  // Mux the granted requester's fields
  always_comb begin
    if (acc[1]) begin
      sel     = '{port: 1'b1, we: bus.req1_we, flag: bus.req1_flag,
                  off: bus.req1_addr[1:0], wdata: bus.req1_wdata};
      sel_idx = bus.req1_addr[MEM_AW+1:2];
    end else begin
      sel     = '{port: 1'b0, we: bus.req0_we, flag: bus.req0_flag,
                  off: bus.req0_addr[1:0], wdata: bus.req0_wdata};
      sel_idx = bus.req0_addr[MEM_AW+1:2];
    end
    sel_err = misaligned(sel.flag, sel.off);
  end

  lane_merge u_lane_merge (
    .flag     (r.flag),
    .off      (r.off),
    .old_word (bus.mem_rdata),
    .wdata    (r.wdata),
    .ext_c    (ext_c),
    .merged_c (merged_c)
  );

  // Next state and next registered outputs
  always_comb begin
    state_n     = state;
    r_n         = r;
    ptr_n       = ptr;
    port_n      = r.port;
    rsp_rdata_n = '0;
    rsp_err_n   = 1'b0;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;
    case (state)
      ST_IDLE: begin
        if (|acc) begin
          r_n    = sel;
          ptr_n  = sel.port;
          port_n = sel.port;
          if (sel_err) begin
            state_n   = ST_RESP;
            rsp_err_n = 1'b1;
          end else begin
            mem_addr_n = sel_idx;
            if (sel.we && is_word(sel.flag)) begin
              state_n     = ST_WR;
              mem_wdata_n = sel.wdata;
            end else begin
              state_n = ST_RD;
            end
          end
        end
      end
      ST_RD:  state_n = ST_CAP;
      ST_CAP: begin
        if (r.we) begin
          state_n     = ST_WR;
          mem_wdata_n = merged_c;
        end else begin
          state_n     = ST_RESP;
          rsp_rdata_n = ext_c;
        end
      end
      ST_WR:   state_n = ST_RESP;
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    mem_en_n    = (state_n == ST_RD) || (state_n == ST_WR);
    mem_we_n    = (state_n == ST_WR);
    busy_n      = (state_n != ST_IDLE);
    rsp_valid_n = (state_n == ST_RESP) ? (port_n ? 2'b10 : 2'b01) : 2'b00;
    ready_n     = 2'b00;
    if (state_n == ST_IDLE) begin
      ready_n[0] = bus.req0_valid & (~bus.req1_valid | ptr_n);
      ready_n[1] = bus.req1_valid & (~bus.req0_valid | ~ptr_n);
    end
  end

  // State, captured request and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      r           <= '0;
      ptr         <= 1'b1;
      ready_q     <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_n;
      r           <= r_n;
      ptr         <= ptr_n;
      ready_q     <= ready_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
      rsp_err_q   <= rsp_err_n;
      mem_en_q    <= mem_en_n;
      mem_we_q    <= mem_we_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
      busy_q      <= busy_n;
    end
  end

  assign bus.req0_ready = ready_q[0];
  assign bus.req1_ready = ready_q[1];
  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp0_rdata = rsp_valid_q[0] ? rsp_rdata_q : '0;
  assign bus.rsp1_rdata = rsp_valid_q[1] ? rsp_rdata_q : '0;
  assign bus.rsp0_err   = rsp_valid_q[0] & rsp_err_q;
  assign bus.rsp1_err   = rsp_valid_q[1] & rsp_err_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = busy_q;
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing controller and two-port round-robin arbiter in front of the CPU's single-port data memory. It accepts word, halfword and byte load/store requests from two requesters and turns sub-word stores into read-modify-write cycles. Requester 0 is the load/store stage; requester 1 is the program/debug loader. It also owns lane selection and misalignment checks, so the memory array only ever sees full-word accesses.

## Interface
- `ADDR_W`, default 32: request byte-address width.
- `DATA_W`, default 32: data width; only 32 is supported.
- `MEM_AW`, default 6: memory word-index width (64 words).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `reqN_valid`  in  1: request N present, for N = 0, 1.
- `reqN_ready`  out  1: request N accepted this cycle when high together with `reqN_valid`.
- `reqN_we`  in  1: 1 = store, 0 = load.
- `reqN_flag`  in  2: size. 00 = word, 01 = halfword, 10 = byte, 11 = word.
- `reqN_addr`  in  ADDR_W: byte address.
- `reqN_wdata`  in  32: store data, right-aligned.
- `rspN_valid`  out  1: one-cycle response pulse.
- `rspN_rdata`  out  32: load data, zero-extended and right-aligned; 0 for stores.
- `rspN_err`  out  1: misaligned request; qualified by `rspN_valid`.
- `mem_en`  out  1: memory access strobe.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  MEM_AW: word index.
- `mem_wdata`  out  32: full-word write data.
- `mem_rdata`  in  32: synchronous read data, valid the cycle after `mem_en & ~mem_we`.
- `busy`  out  1: state is not IDLE.

## Operation
- Address decode:
  - word index = `addr[MEM_AW+1:2]`; higher address bits are ignored, so addresses wrap modulo 2^(MEM_AW+2).
  - Lanes are little-endian. Byte lane k = bits [8k+7:8k] with k = `addr[1:0]`. Halfword lane = `addr[1]` selects [15:0] or [31:16].
- Misalignment:
  - a word access with `addr[1:0]` ≠ 0 is an error;
  - a halfword access with `addr[0]` = 1 is an error;
  - on error: no memory activity, response carries `err` = 1 and `rdata` = 0.
- Arbitration:
  - round-robin with a 1-bit last-served pointer; reset value favours port 0;
  - in IDLE, ready goes to the single valid requester, or to the non-last-served one when both are valid;
  - the pointer updates only on accept;
  - `reqN_ready` is 0 outside IDLE.
- FSM states: IDLE, RD, CAP, WR, RESP. The accepted request (port id, we, flag, addr, wdata) is registered on accept.
  - Error: IDLE→RESP.
  - Load: IDLE→RD→CAP→RESP.
  - Word store: IDLE→WR→RESP.
  - Sub-word store: IDLE→RD→CAP→WR→RESP.
- Per-state actions:
  - RD drives `mem_en` = 1, `mem_we` = 0.
  - CAP registers `mem_rdata`. For a load it extracts the lane and zero-extends. For a store it merges `wdata` into the selected lane and leaves the other lanes untouched.
  - WR drives `mem_en` = 1, `mem_we` = 1 with the full merged word.
  - RESP pulses `rspN_valid` for the owning port only, then goes to IDLE.
- Outputs are registered. At reset every output is 0: ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata, busy. State = IDLE, pointer = 1 (port 0 favoured).

## Timing
- Accept at cycle T (valid & ready in IDLE). Response pulse cycle:
  - error: T+1;
  - word store: T+2;
  - load: T+3;
  - sub-word store: T+4.
- The next accept is possible in the cycle after RESP, so there is at most one outstanding transaction.
- The requester holds its request fields stable only until accept; the controller uses only registered copies after that.
- A requester not granted keeps `valid` high and is served next; starvation is bounded to one transaction.
- Async reset mid-transaction:
  - immediately drops `mem_en`/`mem_we` and returns to IDLE;
  - the in-flight request is discarded with no response;
  - a partially done RMW leaves memory unmodified, because the write happens only in WR.
- `mem_rdata` is sampled only in CAP; its value in other cycles is ignored.

## Structure
- Shared definitions file holds:
  - size codes SZ_WORD = 2'b00, SZ_HALF = 2'b01, SZ_BYTE = 2'b10, SZ_WORD2 = 2'b11;
  - state encodings;
  - the memory word-index width, matching the data-memory depth.
- One natural sub-module, `lane_merge`: purely combinational lane extract (load) and lane insert (store) from flag, `addr[1:0]`, old word and wdata. It is reused by CAP for both paths.

## Test plan
- Word store then load: port 0 stores 0xDEADBEEF at 0x10 (rsp at T+2, err 0), then loads 0x10 → `rdata` 0xDEADBEEF at T+3; `mem_addr` = 4.
- Sub-word RMW: memory word 4 = 0x11223344; port 0 byte-stores 0xAA at 0x12 → word 4 becomes 0x11AA3344 with one read and one write, rsp at T+4. A halfword load from 0x12 → 0x000011AA.
- Misalignment: word load at 0x13 and halfword store at 0x11 → `err` = 1 at T+1, `rdata` 0, `mem_en` never asserted, memory unchanged.
- Arbitration: both ports valid continuously for 4 transactions → grants alternate 0,1,0,1; with only port 1 valid it is granted immediately.
- Reset mid-RMW: assert `rst_n` = 0 during CAP of a byte store → outputs 0 asynchronously, no `rsp`, target word unchanged, next request is served from IDLE.
- Wrap: load at 0x100 with `MEM_AW` = 6 → `mem_addr` = 0.
